// File: rtl/rc5_key_expand.sv
// rc5_key_expand
//   Sequential RC5-16/r/8 key-schedule generator. Latches a 64-bit key and a
//   round count, builds the initial magic-constant table, then runs one mix
//   iteration per clock. The finished table S[0:33] sits on `subkeys` while
//   `done` is high.
//
// Ports
//   clk         in   1    rising-edge clock
//   rst_n       in   1    synchronous active-low reset
//   start       in   1    expansion request, honoured only in IDLE and DONE
//   num_rounds  in   5    round count r; values above 16 behave as 16
//   key         in   64   secret key, L[k] = key[16k+15:16k]
//   busy        out  1    high during INIT and MIX
//   done        out  1    high in DONE; subkeys valid and frozen
//   subkeys     out  544  S[k] at subkeys[16k+15:16k]; entries >= t read 0
//   state_dbg   out  2    current FSM state (0 IDLE, 1 INIT, 2 MIX, 3 DONE)
//
// Handshake: a request is a cycle in which start=1 while done=1 or the block
// is idle; the table is valid for exactly the cycles in which done=1, and
// busy and done are never high together.

module rc5_key_expand #(
   parameter logic [15:0] P_W = 16'hB7E1,
   parameter logic [15:0] Q_W = 16'h9E37
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [4:0]   num_rounds,
   input  logic [63:0]  key,
   output logic         busy,
   output logic         done,
   output logic [543:0] subkeys,
   output logic [1:0]   state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INIT = 2'd1,
      ST_MIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] s_q [34];
   logic [15:0] s_d [34];
   logic [15:0] l_q [4];
   logic [15:0] l_d [4];
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [5:0]  i_q, i_d;
   logic [1:0]  j_q, j_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [5:0]  t_q, t_d;

   // Derived parameters of a new request
   logic [4:0]  rc_clamp;
   logic [5:0]  t_in;
   logic [5:0]  t_floor;
   logic [6:0]  cnt_init;

   assign rc_clamp = (num_rounds > 5'd16) ? 5'd16 : num_rounds;
   assign t_in     = {rc_clamp, 1'b0} + 6'd2;
   // Short tables still get 3*4 iterations so every L word is mixed 3 times.
   assign t_floor  = (t_q < 6'd4) ? 6'd4 : t_q;
   assign cnt_init = {1'b0, t_floor} + {t_floor, 1'b0} - 7'd1;

   // One mix iteration
   logic [15:0] sum_a;
   logic [15:0] a_new;
   logic [15:0] sum_b;
   logic [3:0]  rot_b;
   logic [31:0] rot_wide;
   logic [15:0] b_new;
   logic [5:0]  i_inc;

   assign sum_a    = s_q[i_q] + a_q + b_q;
   assign a_new    = {sum_a[12:0], sum_a[15:13]};
   assign sum_b    = l_q[j_q] + a_new + b_q;
   // Low nibble of (A'+B) equals the 4-bit sum of the low nibbles.
   assign rot_b    = a_new[3:0] + b_q[3:0];
   // Rotate-left by shifting a doubled word and keeping the upper half.
   assign rot_wide = {sum_b, sum_b} << rot_b;
   assign b_new    = rot_wide[31:16];
   assign i_inc    = i_q + 6'd1;

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         for (int k = 0; k < 34; k++) s_q[k] <= 16'h0;
         for (int k = 0; k < 4; k++)  l_q[k] <= 16'h0;
         a_q   <= 16'h0;
         b_q   <= 16'h0;
         i_q   <= 6'd0;
         j_q   <= 2'd0;
         cnt_q <= 7'd0;
         t_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         for (int k = 0; k < 34; k++) s_q[k] <= s_d[k];
         for (int k = 0; k < 4; k++)  l_q[k] <= l_d[k];
         a_q   <= a_d;
         b_q   <= b_d;
         i_q   <= i_d;
         j_q   <= j_d;
         cnt_q <= cnt_d;
         t_q   <= t_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_INIT;
         ST_INIT: state_d = ST_MIX;
         ST_MIX:  if (cnt_q == 7'd0) state_d = ST_DONE;
         ST_DONE: if (start) state_d = ST_INIT;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      for (int k = 0; k < 34; k++) s_d[k] = s_q[k];
      for (int k = 0; k < 4; k++)  l_d[k] = l_q[k];
      a_d   = a_q;
      b_d   = b_q;
      i_d   = i_q;
      j_d   = j_q;
      cnt_d = cnt_q;
      t_d   = t_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               for (int k = 0; k < 4; k++) l_d[k] = key[16*k +: 16];
               t_d = t_in;
            end
         end
         ST_INIT: begin
            for (int k = 0; k < 34; k++) begin
               s_d[k] = (6'(k) < t_q) ? (P_W + 16'(k) * Q_W) : 16'h0;
            end
            a_d   = 16'h0;
            b_d   = 16'h0;
            i_d   = 6'd0;
            j_d   = 2'd0;
            cnt_d = cnt_init;
         end
         ST_MIX: begin
            s_d[i_q] = a_new;
            l_d[j_q] = b_new;
            a_d      = a_new;
            b_d      = b_new;
            i_d      = (i_inc == t_q) ? 6'd0 : i_inc;
            j_d      = j_q + 2'd1;
            if (cnt_q != 7'd0) cnt_d = cnt_q - 7'd1;
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      busy      = (state_q == ST_INIT) || (state_q == ST_MIX);
      done      = (state_q == ST_DONE);
      state_dbg = state_q;
      subkeys   = '0;
      for (int k = 0; k < 34; k++) subkeys[16*k +: 16] = s_q[k];
   end

endmodule
